// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin on ties, grant held while the owner keeps cyc high.
// Optional bus timeout (stalled strobe -> error to the owner) enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   stb_raw_s;
    logic   timeout_s;
    logic   ack_fwd_s, err_fwd_s, rty_fwd_s;

    // State and last-grant registers; reset leaves m1 as last owner so m0 wins the first tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state arbitration
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (m1_cyc_i) begin
                    state_d = GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0) begin
            last_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    // Request mux from the granted master onto the slave port
    always_comb begin
        s_cyc_o   = 1'b0;
        stb_raw_s = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = 32'd0;
        s_dat_o   = 32'd0;
        s_sel_o   = 4'd0;
        gnt_o     = 2'b00;
        case (state_q)
            GNT0: begin
                s_cyc_o   = m0_cyc_i;
                stb_raw_s = m0_stb_i;
                s_we_o    = m0_we_i;
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
                s_sel_o   = m0_sel_i;
                gnt_o     = 2'b01;
            end
            GNT1: begin
                s_cyc_o   = m1_cyc_i;
                stb_raw_s = m1_stb_i;
                s_we_o    = m1_we_i;
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
                s_sel_o   = m1_sel_i;
                gnt_o     = 2'b10;
            end
            default: gnt_o = 2'b00;
        endcase
    end

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        stall_s;

    // Stall counter; a timeout also clears it so the next stall starts fresh
    always_comb begin
        stall_s   = stb_raw_s & ~(s_ack_i | s_err_i | s_rty_i);
        timeout_s = stall_s & (cnt_q == TO_LAST);
        if (stall_s && !timeout_s && (state_d == state_q)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_s;

    assign unused_timeout_s = ^TO_LAST;
    assign timeout_s        = 1'b0;
`endif

    // Response routing; responses are only honoured while a strobe is actually presented
    always_comb begin
        s_stb_o   = stb_raw_s & ~timeout_s;
        ack_fwd_s = s_ack_i & s_stb_o;
        err_fwd_s = (s_err_i & s_stb_o) | timeout_s;
        rty_fwd_s = s_rty_i & s_stb_o;
        m0_dat_o  = s_dat_i;
        m1_dat_o  = s_dat_i;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_rty_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_rty_o  = 1'b0;
        if (state_q == GNT0) begin
            m0_ack_o = ack_fwd_s;
            m0_err_o = err_fwd_s;
            m0_rty_o = rty_fwd_s;
        end else if (state_q == GNT1) begin
            m1_ack_o = ack_fwd_s;
            m1_err_o = err_fwd_s;
            m1_rty_o = rty_fwd_s;
        end else begin
            m0_ack_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grant latency, round-robin, burst hold, reset abort, stall timeout.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [1:0]  gnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        m0_adr_i = 32'd0; m0_dat_i = 32'd0; m0_sel_i = 4'd0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m1_adr_i = 32'd0; m1_dat_i = 32'd0; m1_sel_i = 4'd0;
        s_dat_i = 32'd0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #3;
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_stb", 32'(s_stb_o), 32'd0);
        tick();
        clear_inputs();
        rst_i = 1'b0;

        // m0 read alone: grant one cycle after the request
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_1000; m0_sel_i = 4'hF;
        #1;
        check("lat_gnt_idle", 32'(gnt_o), 32'd0);
        tick();
        check("rd_gnt", 32'(gnt_o), 32'h1);
        check("rd_adr", s_adr_o, 32'h0000_1000);
        check("rd_sel", 32'(s_sel_o), 32'hF);
        check("rd_cyc", 32'(s_cyc_o), 32'd1);
        check("rd_ack_wait", 32'(m0_ack_o), 32'd0);
        m0_stb_i = 1'b0; s_ack_i = 1'b1;
        #1;
        check("drop_ack_nostb", 32'(m0_ack_o), 32'd0);
        m0_stb_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        check("rd_ack", 32'(m0_ack_o), 32'd1);
        check("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("rd_dat_m1", m1_dat_o, 32'hDEAD_BEEF);
        check("rd_m1_ack", 32'(m1_ack_o), 32'd0);
        tick();
        clear_inputs();
        tick();
        check("rd_idle", 32'(gnt_o), 32'd0);

        // Tie with m0 as last owner: m1 wins
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        check("rr_m1_wins", 32'(gnt_o), 32'h2);
        clear_inputs();
        tick();
        check("rr_idle", 32'(gnt_o), 32'd0);

        // Reset pulse, then simultaneous requests: m0 first, m0 burst holds grant
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_2000;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_3000;
        tick();
        check("tie_gnt", 32'(gnt_o), 32'h1);
        check("tie_adr", s_adr_o, 32'h0000_2000);
        s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_dat_i = 32'h1111_0000 + 32'(i);
            #1;
            check("burst_gnt", 32'(gnt_o), 32'h1);
            check("burst_m0_ack", 32'(m0_ack_o), 32'd1);
            check("burst_m1_ack", 32'(m1_ack_o), 32'd0);
            tick();
        end
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        check("handoff_pre", 32'(gnt_o), 32'h1);
        tick();
        check("handoff_gnt", 32'(gnt_o), 32'h2);
        check("handoff_adr", s_adr_o, 32'h0000_3000);

        // m1 write aborted by reset
        m1_we_i = 1'b1; m1_dat_i = 32'h5555_AAAA; m1_sel_i = 4'h3; s_ack_i = 1'b1;
        #1;
        check("wr_we", 32'(s_we_o), 32'd1);
        check("wr_dat", s_dat_o, 32'h5555_AAAA);
        check("wr_stb", 32'(s_stb_o), 32'd1);
        check("wr_m1_ack", 32'(m1_ack_o), 32'd1);
        check("wr_m0_ack", 32'(m0_ack_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check("abort_cyc", 32'(s_cyc_o), 32'd0);
        check("abort_stb", 32'(s_stb_o), 32'd0);
        check("abort_gnt", 32'(gnt_o), 32'd0);
        check("abort_ack", 32'(m1_ack_o), 32'd0);
        s_ack_i = 1'b0;
        tick();
        rst_i = 1'b0;
        tick();
        check("resume_gnt", 32'(gnt_o), 32'h2);
        clear_inputs();
        tick();
        check("resume_idle", 32'(gnt_o), 32'd0);

        // Stalled slave with m0 strobing
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_4000;
        tick();
        for (int k = 1; k < 8; k++) begin
            check("stall_err", 32'(m0_err_o), 32'd0);
            check("stall_stb", 32'(s_stb_o), 32'd1);
            tick();
        end
`ifdef WB_ARBITER_TIMEOUT_EN
        check("to_err", 32'(m0_err_o), 32'd1);
        check("to_stb", 32'(s_stb_o), 32'd0);
        check("to_m1_err", 32'(m1_err_o), 32'd0);
        tick();
        check("to_after_err", 32'(m0_err_o), 32'd0);
        check("to_after_stb", 32'(s_stb_o), 32'd1);
`else
        check("noto_err", 32'(m0_err_o), 32'd0);
        check("noto_stb", 32'(s_stb_o), 32'd1);
        tick();
        tick();
        check("noto_hold_gnt", 32'(gnt_o), 32'h1);
        check("noto_hold_err", 32'(m0_err_o), 32'd0);
`endif
        check("stall_gnt", 32'(gnt_o), 32'h1);
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255: the number of stalled strobe cycles before a bus timeout (range 2..65535).
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock; all sequential logic on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have ports m0_cyc_i, m0_stb_i and m0_we_i, input, 1 bit each: master 0 (CPU) Wishbone cycle, strobe and write enable.
REQ-005 The block SHALL have ports m0_adr_i and m0_dat_i, input, 32 bits each, and m0_sel_i, input, 4 bits: master 0 address, write data and byte select.
REQ-006 The block SHALL have port m0_dat_o, output, 32 bits, and ports m0_ack_o, m0_err_o and m0_rty_o, output, 1 bit each: master 0 read data and responses.
REQ-007 The block SHALL have ports m1_* with the same names, directions and widths as m0_*: master 1 (DMA/debug).
REQ-008 The block SHALL have ports s_cyc_o, s_stb_o and s_we_o, output, 1 bit each; s_adr_o and s_dat_o, output, 32 bits each; and s_sel_o, output, 4 bits: the shared slave request.
REQ-009 The block SHALL have port s_dat_i, input, 32 bits, and ports s_ack_i, s_err_i and s_rty_i, input, 1 bit each: the shared slave responses.
REQ-010 The block SHALL have port gnt_o, output, 2 bits: one-hot current grant (01 = m0, 10 = m1, 00 = none).

Function
REQ-011 The state machine SHALL have three states, IDLE, GNT0 and GNT1, and SHALL hold a registered last-grant bit.
REQ-012 In IDLE with exactly one mN_cyc_i high, the next state SHALL be GNTN.
REQ-013 In IDLE with both cyc high, the master not in last-grant SHALL win (round-robin); last-grant SHALL update on entry to any GNT state.
REQ-014 Grant latency SHALL be 1 cycle: a request seen in IDLE is driven on s_* in the following cycle.
REQ-015 In GNTN, the s_* request signals SHALL be combinational copies of mN_*, and s_cyc_o SHALL equal mN_cyc_i.
REQ-016 In GNTN, mN_ack_o, mN_err_o and mN_rty_o SHALL mirror the slave responses combinationally; the other master's responses SHALL be 0.
REQ-017 s_dat_i SHALL be routed to both m0_dat_o and m1_dat_o unconditionally.
REQ-018 Grant SHALL be held while mN_cyc_i=1, regardless of the other master's requests.
REQ-019 When the granted master drops cyc: if the other master's cyc=1, the next state SHALL be that master's GNT state directly; otherwise it SHALL be IDLE.
REQ-020 In IDLE, all s_* outputs SHALL be 0, all master responses SHALL be 0, and gnt_o SHALL be 00.
REQ-021 A response arriving while s_stb_o=0 SHALL be dropped and not forwarded.

Reset
REQ-022 Asserting rst_i SHALL immediately force: state IDLE, last-grant = m1 (so m0 wins the first tie), timeout counter 0.
REQ-023 Outputs SHALL take their REQ-020 values while rst_i is high, including when reset is asserted mid-transfer.
REQ-024 After rst_i deasserts, arbitration SHALL resume at the first rising edge of clk_i.

Configuration
REQ-025 With macro WB_ARBITER_TIMEOUT_EN defined, a 16-bit counter SHALL increment each cycle that s_stb_o=1 and s_ack_i, s_err_i and s_rty_i are all 0, and SHALL clear on any response, on stb low, or on a grant change.
REQ-026 With WB_ARBITER_TIMEOUT_EN defined, when the counter equals TIMEOUT_CYCLES-1 and no response is present, the block SHALL for that one cycle assert mN_err_o=1 to the granted master, force s_stb_o=0, and clear the counter.
REQ-027 With WB_ARBITER_TIMEOUT_EN undefined, the counter logic SHALL be absent and a stalled slave SHALL hold the grant indefinitely.

Verification
REQ-028 The bench SHALL cover: m0 read with only m0 requesting -> gnt_o=01 one cycle later, s_adr_o=m0_adr_i, and m0_ack_o/m0_dat_o follow the slave's ack with data 32'hDEAD_BEEF.
REQ-029 The bench SHALL cover: both cyc rising in the same cycle after reset -> m0 granted first; after m0 drops cyc, m1 is granted in the next cycle with no IDLE cycle.
REQ-030 The bench SHALL cover: m1 requesting throughout an m0 burst of 4 acks -> gnt_o stays 01 and m1_ack_o=0 throughout.
REQ-031 The bench SHALL cover: rst_i pulse mid m1 write with s_stb_o=1 -> s_cyc_o and s_stb_o are 0 in the same cycle as the pulse, and gnt_o=00.
REQ-032 The bench SHALL cover, with WB_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave that never acks -> m0_err_o=1 exactly on the 8th stalled cycle, with s_stb_o=0 in that cycle.
